// File: rtl/uart_hex_io_handler.sv
// ASCII-hex request parser / response serialiser between a byte UART and the host master.
// Optional inter-character receive timeout enabled by defining UART_HEX_TIMEOUT_EN.
`ifndef COMMAND_WRITE
`define COMMAND_WRITE 16'h0001
`endif

module uart_hex_io_handler #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned COUNT_WIDTH    = 28,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_valid,
  output logic [7:0]             tx_byte,
  output logic                   tx_en,
  input  logic                   tx_busy,
  input  logic                   master_ready,
  output logic                   ih_ready,
  output logic [DATA_WIDTH-1:0]  in_command,
  output logic [DATA_WIDTH-1:0]  in_address,
  output logic [DATA_WIDTH-1:0]  in_data,
  output logic [COUNT_WIDTH-1:0] in_data_count,
  output logic                   rx_error,
  output logic                   oh_ready,
  input  logic                   oh_en,
  input  logic [DATA_WIDTH-1:0]  out_status,
  input  logic [DATA_WIDTH-1:0]  out_address,
  input  logic [DATA_WIDTH-1:0]  out_data,
  input  logic [COUNT_WIDTH-1:0] out_data_count
);

  localparam int unsigned CN   = COUNT_WIDTH / 4;
  localparam int unsigned WN   = DATA_WIDTH / 4;
  localparam int unsigned MaxN = (CN > WN) ? CN : WN;
  localparam int unsigned NibW = $clog2(MaxN + 1);
  localparam int unsigned CmdW = (DATA_WIDTH < 16) ? DATA_WIDTH : 16;
  localparam logic [CmdW-1:0] CmdWrite = CmdW'(`COMMAND_WRITE);

  typedef enum logic [2:0] {RIdle, RCount, RCmd, RAddr, RData, RDeliver} rx_state_e;
  typedef enum logic [2:0] {TIdle, TSof, TCount, TStatus, TAddr, TData, TNext} tx_state_e;

  // {valid, nibble}; letters of either case map via the low nibble plus 9
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return {1'b1, b[3:0]};
    if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) return {1'b1, b[3:0] + 4'd9};
    return 5'd0;
  endfunction

  // ---------------------------------------------------------------- receive
  rx_state_e              rx_state_q, rx_state_d;
  logic [NibW-1:0]        rx_nib_q, rx_nib_d, rx_last;
  logic [DATA_WIDTH-1:0]  cmd_q, cmd_d, addr_q, addr_d, data_q, data_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [4:0]             rx_dec;
  logic                   rx_clear, ih_ready_c, rx_error_c, timeout_hit;

  assign rx_dec  = hex_decode(rx_byte);
  assign rx_last = (rx_state_q == RCount) ? NibW'(CN - 1) : NibW'(WN - 1);

`ifdef UART_HEX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          rx_in_field;

  assign rx_in_field = (rx_state_q != RIdle) && (rx_state_q != RDeliver);
  assign timer_d     = (rx_valid || !rx_in_field) ? '0 : timer_q + TW'(1);
  assign timeout_hit = rx_in_field && !rx_valid && (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    rx_state_d = rx_state_q;
    rx_nib_d   = rx_nib_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    rx_clear   = 1'b0;
    ih_ready_c = 1'b0;
    rx_error_c = 1'b0;
    unique case (rx_state_q)
      RIdle: begin
        if (rx_valid && rx_byte == 8'h4C) begin
          rx_clear   = 1'b1;
          rx_state_d = RCount;
        end
      end
      RCount, RCmd, RAddr, RData: begin
        if (rx_valid) begin
          if (!rx_dec[4]) begin
            rx_error_c = 1'b1;
            rx_clear   = 1'b1;
            rx_state_d = RIdle;
          end else begin
            case (rx_state_q)
              RCount:  cnt_d  = (cnt_q << 4) | COUNT_WIDTH'(rx_dec[3:0]);
              RCmd:    cmd_d  = (cmd_q << 4) | DATA_WIDTH'(rx_dec[3:0]);
              RAddr:   addr_d = (addr_q << 4) | DATA_WIDTH'(rx_dec[3:0]);
              default: data_d = (data_q << 4) | DATA_WIDTH'(rx_dec[3:0]);
            endcase
            if (rx_nib_q == rx_last) begin
              rx_nib_d = '0;
              case (rx_state_q)
                RCount:  rx_state_d = RCmd;
                RCmd:    rx_state_d = RAddr;
                RAddr:   rx_state_d = RData;
                default: rx_state_d = RDeliver;
              endcase
            end else begin
              rx_nib_d = rx_nib_q + NibW'(1);
            end
          end
        end
      end
      RDeliver: begin
        if (master_ready) begin
          ih_ready_c = 1'b1;
          // Writes loop back for another data word until the count is spent
          if (cmd_q[CmdW-1:0] == CmdWrite && cnt_q != '0) begin
            cnt_d      = cnt_q - COUNT_WIDTH'(1);
            data_d     = '0;
            rx_nib_d   = '0;
            rx_state_d = RData;
          end else begin
            rx_state_d = RIdle;
          end
        end
      end
      default: rx_state_d = RIdle;
    endcase
    if (timeout_hit) begin
      rx_error_c = 1'b1;
      rx_clear   = 1'b1;
      rx_state_d = RIdle;
    end
    if (rx_clear) begin
      cmd_d    = '0;
      addr_d   = '0;
      data_d   = '0;
      cnt_d    = '0;
      rx_nib_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RIdle;
      rx_nib_q   <= '0;
      cmd_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_nib_q   <= rx_nib_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
    end
  end

  // --------------------------------------------------------------- transmit
  tx_state_e              tx_state_q, tx_state_d;
  logic [NibW-1:0]        tx_nib_q, tx_nib_d, tx_last;
  logic [COUNT_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
  logic [DATA_WIDTH-1:0]  tx_status_q, tx_status_d, tx_addr_q, tx_addr_d, tx_data_q, tx_data_d;
  logic                   tx_wait_q, tx_wait_d, tx_en_q, tx_en_d, tx_send, oh_ready_c;
  logic [7:0]             tx_byte_q, tx_byte_d, tx_char;
  logic [3:0]             tx_cur;
  int                     tx_shift;

  assign tx_last  = (tx_state_q == TCount) ? NibW'(CN - 1) : NibW'(WN - 1);
  assign tx_shift = 4 * (int'(tx_last) - int'(tx_nib_q));
  assign tx_send  = !tx_busy && !tx_wait_q;
  assign tx_char  = (tx_cur < 4'd10) ? (8'h30 + {4'h0, tx_cur}) : (8'h37 + {4'h0, tx_cur});

  always_comb begin
    unique case (tx_state_q)
      TCount:  tx_cur = 4'(tx_cnt_q >> tx_shift);
      TStatus: tx_cur = 4'(tx_status_q >> tx_shift);
      TAddr:   tx_cur = 4'(tx_addr_q >> tx_shift);
      default: tx_cur = 4'(tx_data_q >> tx_shift);
    endcase
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_nib_d    = tx_nib_q;
    tx_cnt_d    = tx_cnt_q;
    tx_status_d = tx_status_q;
    tx_addr_d   = tx_addr_q;
    tx_data_d   = tx_data_q;
    tx_byte_d   = tx_byte_q;
    tx_en_d     = 1'b0;
    // Wait holds off a second strobe until the UART has acknowledged by going busy
    tx_wait_d   = tx_busy ? 1'b0 : tx_wait_q;
    oh_ready_c  = 1'b0;
    unique case (tx_state_q)
      TIdle: begin
        oh_ready_c = 1'b1;
        if (oh_en) begin
          tx_status_d = out_status;
          tx_addr_d   = out_address;
          tx_data_d   = out_data;
          tx_cnt_d    = out_data_count;
          tx_nib_d    = '0;
          tx_state_d  = TSof;
        end
      end
      TSof: begin
        if (tx_send) begin
          tx_en_d    = 1'b1;
          tx_byte_d  = 8'h53;
          tx_wait_d  = 1'b1;
          tx_state_d = TCount;
        end
      end
      TCount, TStatus, TAddr, TData: begin
        if (tx_send) begin
          tx_en_d   = 1'b1;
          tx_byte_d = tx_char;
          tx_wait_d = 1'b1;
          if (tx_nib_q == tx_last) begin
            tx_nib_d = '0;
            case (tx_state_q)
              TCount:  tx_state_d = TStatus;
              TStatus: tx_state_d = TAddr;
              TAddr:   tx_state_d = TData;
              default: tx_state_d = TNext;
            endcase
          end else begin
            tx_nib_d = tx_nib_q + NibW'(1);
          end
        end
      end
      TNext: begin
        if (tx_cnt_q != '0) begin
          oh_ready_c = 1'b1;
          if (oh_en) begin
            tx_data_d  = out_data;
            tx_cnt_d   = tx_cnt_q - COUNT_WIDTH'(1);
            tx_nib_d   = '0;
            tx_state_d = TData;
          end
        end else begin
          tx_state_d = TIdle;
        end
      end
      default: tx_state_d = TIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q  <= TIdle;
      tx_nib_q    <= '0;
      tx_cnt_q    <= '0;
      tx_status_q <= '0;
      tx_addr_q   <= '0;
      tx_data_q   <= '0;
      tx_byte_q   <= '0;
      tx_en_q     <= 1'b0;
      tx_wait_q   <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_nib_q    <= tx_nib_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_status_q <= tx_status_d;
      tx_addr_q   <= tx_addr_d;
      tx_data_q   <= tx_data_d;
      tx_byte_q   <= tx_byte_d;
      tx_en_q     <= tx_en_d;
      tx_wait_q   <= tx_wait_d;
    end
  end

  // Strobes are masked during reset so an aborted frame emits nothing
  assign ih_ready      = ih_ready_c & ~rst;
  assign rx_error      = rx_error_c & ~rst;
  assign oh_ready      = oh_ready_c & ~rst;
  assign tx_en         = tx_en_q & ~rst;
  assign tx_byte       = tx_byte_q;
  assign in_command    = cmd_q;
  assign in_address    = addr_q;
  assign in_data       = data_q;
  assign in_data_count = cnt_q;

endmodule

// File: doc/uart_hex_io_handler.md
# uart_hex_io_handler

Parametrised ASCII-hex packet codec between a byte-level UART core and the host-interface master. Parses `L<count><command><address><data...>` request frames from received bytes into command/address/data words, and serialises `S<count><status><address><data...>` response frames into transmit bytes. Compared with the fixed 32-bit UART handler, it generalises the data and count field widths, accepts lowercase hex, and flags framing errors. It also has an optional inter-character timeout. It sits between the `uart` core and the wishbone master, and is instantiated by the UART host-interface top.

## Interface
Parameters:
- DATA_WIDTH, 32, width of command/address/data/status words; must be a multiple of 4, minimum 8
- COUNT_WIDTH, 28, width of the data-count field; must be a multiple of 4
- TIMEOUT_CYCLES, 100000, idle clk cycles between received bytes before the frame is aborted (timeout build only)

Ports:
- clk  in  1  system clock, all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- rx_byte  in  8  received byte from the UART core
- rx_valid  in  1  one-cycle strobe; rx_byte is valid
- tx_byte  out  8  byte to transmit
- tx_en  out  1  one-cycle transmit strobe
- tx_busy  in  1  UART transmitter busy
- master_ready  in  1  master can accept a word
- ih_ready  out  1  one-cycle strobe; in_* fields are valid
- in_command, in_address, in_data  out  DATA_WIDTH  parsed request fields
- in_data_count  out  COUNT_WIDTH  remaining data-word count
- rx_error  out  1  one-cycle strobe on a framing error or timeout
- oh_ready  out  1  output side can accept a word
- oh_en  in  1  master presents a response word
- out_status, out_address, out_data  in  DATA_WIDTH  response fields
- out_data_count  in  COUNT_WIDTH  response data count

## Operation
- Field lengths:
  - CN = COUNT_WIDTH/4 nibbles for the count field.
  - WN = DATA_WIDTH/4 nibbles for each word field.
  - All fields are sent MSB nibble first.
- Valid hex bytes are '0'-'9', 'A'-'F' and 'a'-'f'. Any other byte inside a field:
  - pulse rx_error;
  - clear the in_* registers and the nibble counter;
  - return to R_IDLE.
- Receive states:
  - R_IDLE: wait for 'L'. Any other byte is ignored silently, with no error.
  - R_COUNT (CN nibbles) -> R_CMD (WN) -> R_ADDR (WN) -> R_DATA (WN) -> R_DELIVER.
  - When 'L' is accepted, in_command, in_address, in_data and in_data_count are cleared.
- R_DELIVER:
  - Wait for master_ready, then pulse ih_ready for one cycle.
  - If in_command[15:0] == `COMMAND_WRITE` and in_data_count != 0: decrement in_data_count, clear in_data and the nibble counter, and return to R_DATA.
  - Otherwise go to R_IDLE.
  - A write therefore carries count+1 data words; every other command carries exactly one data word.
- in_* fields hold their values after ih_ready until the next 'L' is accepted or an error occurs.
- Transmit states:
  - T_IDLE: oh_ready=1. On oh_en, latch status, address, data and count, drop oh_ready, and send 'S'.
  - T_COUNT (CN nibbles) -> T_STATUS (WN) -> T_ADDR (WN) -> T_DATA (WN) -> T_NEXT.
  - T_NEXT, count != 0: oh_ready=1. On oh_en, latch out_data, decrement the count, and go to T_DATA.
  - T_NEXT, count == 0: go to T_IDLE.
- Transmitted hex digits are uppercase: nibble<10 -> '0'+n, otherwise 'A'+n-10.
- Receive and transmit paths are independent and may be active in the same cycle.

## Timing
- Reset values: every output is 0. in_* are 0, both state machines are in IDLE, and the wait flag is clear. oh_ready rises on the first cycle after rst falls.
- Reset asserted mid-frame aborts both paths that cycle. No ih_ready, tx_en or rx_error pulse is issued.
- Receive parsing:
  - One rx_valid byte is consumed per cycle.
  - The field register updates on the cycle after rx_valid.
  - ih_ready rises 1 cycle after the last data nibble when master_ready is already high.
  - Otherwise ih_ready rises on the first cycle master_ready is high.
- Transmit handshake:
  - tx_en is issued only when tx_busy=0 and wait=0, and sets wait=1.
  - wait clears on the first cycle tx_busy=1.
  - Consequently, at most one tx_en is issued per byte, and tx_byte is stable from tx_en until tx_busy rises.
- oh_en is sampled only while oh_ready=1.
- out_data_count is latched in the same cycle as oh_en.

## Configuration
- UART_HEX_TIMEOUT_EN defined:
  - A counter runs while the receive path is outside R_IDLE and R_DELIVER. It resets on every rx_valid.
  - When it reaches TIMEOUT_CYCLES-1: pulse rx_error and go to R_IDLE.
  - R_DELIVER never times out.
- UART_HEX_TIMEOUT_EN undefined: there is no counter, and a partial frame waits indefinitely.

## Test plan
- Single read, DATA_WIDTH=32, COUNT_WIDTH=28:
  - Stimulus: "L0000000" + "00000002" + "0000ABCD" + "12345678", master_ready=1.
  - Required: exactly one ih_ready; in_command=0x2, in_address=0xABCD, in_data=0x12345678.
- Burst write:
  - Stimulus: count "0000002", command=`COMMAND_WRITE`, three data words, lowercase "deadbeef" among them.
  - Required: three ih_ready pulses; in_data_count reads 2, 1, 0; the lowercase word decodes to 0xDEADBEEF.
- Framing error:
  - Stimulus: 'G' as the 3rd address nibble.
  - Required: one rx_error pulse, no ih_ready; a following valid frame parses correctly.
- Response:
  - Stimulus: oh_en with status=0xFFFFFFFF, address=0x10, data=0x0A0B0C0D, count=1, then a second word 0x1.
  - Required: tx bytes "S0000001FFFFFFFF00000010" "0A0B0C0D" "00000001"; one tx_en per byte with tx_busy modelled at 10 cycles.
- Timeout:
  - Build with UART_HEX_TIMEOUT_EN and TIMEOUT_CYCLES=50. Stimulus: "L00", then 60 idle cycles.
  - Required: rx_error 50 cycles after the last byte; state returns to R_IDLE.
- Reset mid-transmit:
  - Stimulus: rst asserted after the 5th tx byte.
  - Required: no further tx_en; oh_ready=1 on the cycle after rst deasserts.
